// File: rtl/act_buf_pkg.sv
// Shared types, sizing constants and pointer helpers for the activation buffer
// read and write controllers.
package act_buf_pkg;

    localparam int unsigned DATA_SIZE       = 8;
    localparam int unsigned DEPTH           = 1024;
    localparam int unsigned ADDR_WIDTH      = 32;
    localparam int unsigned EXT_WIDTH       = 32;
    localparam int unsigned INT_WIDTH       = 256;
    localparam int unsigned BEATS_PER_LINE  = INT_WIDTH / EXT_WIDTH;
    localparam int unsigned NUM_LINES       = DEPTH * DATA_SIZE / INT_WIDTH;
    localparam int unsigned LINE_ADDR_WIDTH = $clog2(NUM_LINES);

    typedef enum logic [2:0] {
        DRAIN_IDLE  = 3'd0,
        DRAIN_FETCH = 3'd1,
        DRAIN_WAIT  = 3'd2,
        DRAIN_SEND  = 3'd3,
        DRAIN_DONE  = 3'd4
    } drain_state_e;

    // Circular pointer increment; limit need not be a power of two.
    function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned limit);
        return (ptr >= limit - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/line_serializer.sv
// Holds one buffer line and emits it as narrow beats over valid/ready,
// least-significant beat first.
module line_serializer
    import act_buf_pkg::*;
#(
    parameter int unsigned lineWidth    = INT_WIDTH,
    parameter int unsigned beatWidth    = EXT_WIDTH,
    parameter int unsigned beatsPerLine = BEATS_PER_LINE
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 i_clear,
    input  logic                 i_load,
    input  logic [lineWidth-1:0] i_line,
    input  logic                 i_last_line,
    input  logic                 i_ready,
    output logic [beatWidth-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_last,
    output logic                 o_line_done_c
);

    localparam int unsigned beatIdxWidth = (beatsPerLine > 1) ? $clog2(beatsPerLine) : 1;

    logic [lineWidth-1:0]    r_line;
    logic [beatIdxWidth-1:0] r_beat;
    logic                    r_valid;
    logic                    w_fire;
    logic                    w_final_beat;

    assign w_fire       = r_valid & i_ready;
    assign w_final_beat = (r_beat == beatIdxWidth'(beatsPerLine - 1));

    // Shift the line down one beat per handshake so the output is always the low slice.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_line  <= '0;
            r_beat  <= '0;
            r_valid <= 1'b0;
        end else if (i_clear) begin
            r_line  <= '0;
            r_beat  <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_line  <= i_line;
            r_beat  <= '0;
            r_valid <= 1'b1;
        end else if (w_fire) begin
            r_line <= r_line >> beatWidth;
            r_beat <= r_beat + beatIdxWidth'(1);
            if (w_final_beat) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_data        = r_line[beatWidth-1:0];
    assign o_valid       = r_valid;
    assign o_last        = r_valid & w_final_beat & i_last_line;
    assign o_line_done_c = w_fire & w_final_beat;

endmodule

// File: rtl/activation_drain.sv
// Activation buffer read-side controller: pops lines in FIFO order from the
// buffer and streams them to the host as narrow beats.
module activation_drain
    import act_buf_pkg::*;
#(
    parameter int unsigned dataSize          = DATA_SIZE,
    parameter int unsigned depth             = DEPTH,
    parameter int unsigned addrWidth         = ADDR_WIDTH,
    parameter int unsigned extInterfaceWidth = EXT_WIDTH,
    parameter int unsigned intInterfaceWidth = INT_WIDTH
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         start_i,
    input  logic [addrWidth-1:0]         len_i,
    input  logic                         clear_i,
    output logic                         busy_o,
    output logic                         done_o,
    input  logic [addrWidth-1:0]         write_head_i,
    output logic                         rd_en_o,
    output logic [addrWidth-1:0]         rd_addr_o,
    input  logic [intInterfaceWidth-1:0] rd_data_i,
    output logic [extInterfaceWidth-1:0] ext_data_o,
    output logic                         ext_valid_o,
    input  logic                         ext_ready_i,
    output logic                         ext_last_o,
    output logic [addrWidth-1:0]         read_tail_snoop
);

    localparam int unsigned beatsPerLine  = intInterfaceWidth / extInterfaceWidth;
    localparam int unsigned numLines      = depth * dataSize / intInterfaceWidth;
    localparam int unsigned lineAddrWidth = $clog2(numLines);

    drain_state_e             r_state;
    drain_state_e             w_state_nxt;
    logic [lineAddrWidth-1:0] r_tail;
    logic [lineAddrWidth-1:0] w_tail_nxt;
    logic [addrWidth-1:0]     r_remaining;
    logic [addrWidth-1:0]     w_remaining_nxt;
    logic                     r_busy;
    logic                     r_done;
    logic                     w_empty;
    logic                     w_rd_en;
    logic                     w_load;
    logic                     w_last_line;
    logic                     w_line_done;
    logic                     w_unused_head;

    // head == tail is always empty; the writer must never fill the last slot.
    assign w_empty       = (r_tail == write_head_i[lineAddrWidth-1:0]);
    assign w_last_line   = (r_remaining == addrWidth'(1));
    assign w_unused_head = ^write_head_i[addrWidth-1:lineAddrWidth];

    always_comb begin
        w_state_nxt     = r_state;
        w_tail_nxt      = r_tail;
        w_remaining_nxt = r_remaining;
        w_rd_en         = 1'b0;
        w_load          = 1'b0;
        if (clear_i) begin
            w_state_nxt     = DRAIN_IDLE;
            w_tail_nxt      = '0;
            w_remaining_nxt = '0;
        end else begin
            case (r_state)
                DRAIN_IDLE: begin
                    if (start_i) begin
                        if (len_i != '0) begin
                            w_remaining_nxt = len_i;
                            w_state_nxt     = DRAIN_FETCH;
                        end else begin
                            w_state_nxt = DRAIN_DONE;
                        end
                    end
                end
                DRAIN_FETCH: begin
                    if (!w_empty) begin
                        w_rd_en     = 1'b1;
                        w_tail_nxt  = lineAddrWidth'(wrap_inc(32'(r_tail), numLines));
                        w_state_nxt = DRAIN_WAIT;
                    end
                end
                DRAIN_WAIT: begin
                    w_load      = 1'b1;
                    w_state_nxt = DRAIN_SEND;
                end
                DRAIN_SEND: begin
                    if (w_line_done) begin
                        w_remaining_nxt = r_remaining - addrWidth'(1);
                        w_state_nxt     = w_last_line ? DRAIN_DONE : DRAIN_FETCH;
                    end
                end
                DRAIN_DONE: begin
                    w_state_nxt = DRAIN_IDLE;
                end
                default: begin
                    w_state_nxt = DRAIN_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state     <= DRAIN_IDLE;
            r_tail      <= '0;
            r_remaining <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_tail      <= w_tail_nxt;
            r_remaining <= w_remaining_nxt;
            r_busy      <= (w_state_nxt == DRAIN_FETCH) || (w_state_nxt == DRAIN_WAIT) ||
                           (w_state_nxt == DRAIN_SEND);
            r_done      <= (w_state_nxt == DRAIN_DONE);
        end
    end

    line_serializer #(
        .lineWidth   (intInterfaceWidth),
        .beatWidth   (extInterfaceWidth),
        .beatsPerLine(beatsPerLine)
    ) u_line_serializer (
        .clk          (clk),
        .nrst         (nrst),
        .i_clear      (clear_i),
        .i_load       (w_load),
        .i_line       (rd_data_i),
        .i_last_line  (w_last_line),
        .i_ready      (ext_ready_i),
        .o_data       (ext_data_o),
        .o_valid      (ext_valid_o),
        .o_last       (ext_last_o),
        .o_line_done_c(w_line_done)
    );

    // Read data returns one cycle after rd_en, which is the WAIT cycle.
    assign rd_en_o         = w_rd_en;
    assign rd_addr_o       = addrWidth'(r_tail);
    assign read_tail_snoop = addrWidth'(r_tail);
    assign busy_o          = r_busy;
    assign done_o          = r_done;

endmodule

// File: tb/tb_activation_drain.sv
// Directed and randomized bench for activation_drain against a queue-based
// model of the expected read addresses and beat stream.
`timescale 1ns/1ps
module tb_activation_drain;
    import act_buf_pkg::*;

    logic                       clk          = 1'b0;
    logic                       nrst         = 1'b0;
    logic                       start_i      = 1'b0;
    logic [ADDR_WIDTH-1:0]      len_i        = '0;
    logic                       clear_i      = 1'b0;
    logic                       busy_o;
    logic                       done_o;
    logic [ADDR_WIDTH-1:0]      write_head_i = '0;
    logic                       rd_en_o;
    logic [ADDR_WIDTH-1:0]      rd_addr_o;
    logic [INT_WIDTH-1:0]       rd_data_i    = '0;
    logic [EXT_WIDTH-1:0]       ext_data_o;
    logic                       ext_valid_o;
    logic                       ext_ready_i  = 1'b0;
    logic                       ext_last_o;
    logic [ADDR_WIDTH-1:0]      read_tail_snoop;

    logic [INT_WIDTH-1:0] mem [NUM_LINES];
    int m_tail   = 0;
    int n_checks = 0;
    int n_pass   = 0;

    activation_drain dut (
        .clk            (clk),
        .nrst           (nrst),
        .start_i        (start_i),
        .len_i          (len_i),
        .clear_i        (clear_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .write_head_i   (write_head_i),
        .rd_en_o        (rd_en_o),
        .rd_addr_o      (rd_addr_o),
        .rd_data_i      (rd_data_i),
        .ext_data_o     (ext_data_o),
        .ext_valid_o    (ext_valid_o),
        .ext_ready_i    (ext_ready_i),
        .ext_last_o     (ext_last_o),
        .read_tail_snoop(read_tail_snoop)
    );

    always #5 clk = ~clk;

    // Buffer model: synchronous read, data one cycle after rd_en.
    always @(posedge clk) begin
        if (rd_en_o) rd_data_i <= mem[rd_addr_o[LINE_ADDR_WIDTH-1:0]];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic pick_ready(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return ((cyc % 4) == 0) || ((cyc % 4) == 3);
        return ($urandom_range(0, 3) != 0);
    endfunction

    function automatic logic [INT_WIDTH-1:0] counting_line();
        logic [INT_WIDTH-1:0] l;
        for (int k = 0; k < BEATS_PER_LINE; k++) l[k*EXT_WIDTH +: EXT_WIDTH] = EXT_WIDTH'(k + 1);
        return l;
    endfunction

    function automatic logic [INT_WIDTH-1:0] random_line();
        logic [INT_WIDTH-1:0] l;
        for (int k = 0; k < BEATS_PER_LINE; k++) l[k*EXT_WIDTH +: EXT_WIDTH] = $urandom();
        return l;
    endfunction

    task automatic do_clear();
        @(posedge clk); #1;
        clear_i = 1'b1;
        @(posedge clk); #1;
        clear_i = 1'b0;
        m_tail = 0;
        @(negedge clk);
        check("clear_tail", 64'(read_tail_snoop), 64'(0));
    endtask

    // Run one transfer; the model expects len lines starting at the model tail.
    task automatic drain(input int len, input int rmode, input int head_at, input int new_head,
                         input bit poke);
        logic [EXT_WIDTH-1:0] exp_data[$];
        bit                   exp_last[$];
        int                   exp_addr[$];
        logic [INT_WIDTH-1:0] line;
        logic [EXT_WIDTH-1:0] prev_data;
        int rd_ptr, cyc, nbeat;
        bit seen_done, prev_stall, prev_mid, poked;
        for (int l = 0; l < len; l++) begin
            exp_addr.push_back((m_tail + l) % NUM_LINES);
            line = mem[(m_tail + l) % NUM_LINES];
            for (int k = 0; k < BEATS_PER_LINE; k++) begin
                exp_data.push_back(line[k*EXT_WIDTH +: EXT_WIDTH]);
                exp_last.push_back((l == len - 1) && (k == BEATS_PER_LINE - 1));
            end
        end
        rd_ptr = m_tail; cyc = 0; nbeat = 0; prev_data = '0;
        seen_done = 1'b0; prev_stall = 1'b0; prev_mid = 1'b0; poked = 1'b0;
        @(posedge clk); #1;
        start_i = 1'b1;
        len_i   = ADDR_WIDTH'(len);
        @(posedge clk); #1;
        start_i = 1'b0;
        while (!seen_done && cyc < 2000) begin
            ext_ready_i = pick_ready(rmode, cyc);
            if (head_at >= 0 && cyc == head_at) write_head_i = ADDR_WIDTH'(new_head);
            start_i = 1'b0;
            if (poke && !poked && prev_mid) begin
                start_i = 1'b1;
                len_i   = ADDR_WIDTH'(5);
                poked   = 1'b1;
            end
            @(negedge clk);
            if (cyc == 0) begin
                if (len == 0) check("zero_len_done", 64'(done_o), 64'(1));
                else          check("busy_after_start", 64'(busy_o), 64'(1));
            end
            check("no_read_when_empty",
                  64'(rd_en_o && (rd_ptr == int'(write_head_i[LINE_ADDR_WIDTH-1:0]))), 64'(0));
            if (rd_en_o) begin
                if (exp_addr.size() == 0) check("extra_read", 64'(1), 64'(0));
                else check("rd_addr", 64'(rd_addr_o), 64'(exp_addr.pop_front()));
                rd_ptr = (rd_ptr + 1) % NUM_LINES;
            end
            if (prev_stall) begin
                check("held_valid", 64'(ext_valid_o), 64'(1));
                check("held_data", 64'(ext_data_o), 64'(prev_data));
            end
            if (prev_mid) check("no_bubble", 64'(ext_valid_o), 64'(1));
            prev_mid = 1'b0;
            if (ext_valid_o && ext_ready_i) begin
                if (exp_data.size() == 0) begin
                    check("extra_beat", 64'(1), 64'(0));
                end else begin
                    check("beat_data", 64'(ext_data_o), 64'(exp_data.pop_front()));
                    check("beat_last", 64'(ext_last_o), 64'(exp_last.pop_front()));
                end
                nbeat++;
                prev_mid = (nbeat % BEATS_PER_LINE) != 0;
            end
            prev_stall = ext_valid_o && !ext_ready_i;
            prev_data  = ext_data_o;
            if (done_o) begin
                seen_done = 1'b1;
                check("done_beats_left", 64'(exp_data.size()), 64'(0));
                check("done_reads_left", 64'(exp_addr.size()), 64'(0));
                check("busy_at_done", 64'(busy_o), 64'(0));
            end
            @(posedge clk); #1;
            cyc++;
        end
        start_i = 1'b0;
        ext_ready_i = 1'b0;
        if (!seen_done) check("done_timeout", 64'(0), 64'(1));
        m_tail = (m_tail + len) % NUM_LINES;
        check("tail_after", 64'(read_tail_snoop), 64'(m_tail));
        @(negedge clk);
        check("done_one_cycle", 64'(done_o), 64'(0));
        check("idle_busy", 64'(busy_o), 64'(0));
    endtask

    // Start a counting-pattern transfer and stop with beat 3 presented.
    task automatic run_to_beat3(input int len);
        int fires, cyc;
        for (int l = 0; l < len; l++) mem[(m_tail + l) % NUM_LINES] = counting_line();
        write_head_i = ADDR_WIDTH'((m_tail + len) % NUM_LINES);
        @(posedge clk); #1;
        start_i = 1'b1;
        len_i   = ADDR_WIDTH'(len);
        ext_ready_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        fires = 0; cyc = 0;
        while (fires < 3 && cyc < 100) begin
            @(negedge clk);
            if (ext_valid_o && ext_ready_i) fires++;
            @(posedge clk); #1;
            cyc++;
        end
        check("reach_beat3", 64'(fires), 64'(3));
        ext_ready_i = 1'b0;
    endtask

    initial begin
        int len;
        for (int i = 0; i < NUM_LINES; i++) mem[i] = random_line();
        #12;
        check("rst_busy", 64'(busy_o), 64'(0));
        check("rst_done", 64'(done_o), 64'(0));
        check("rst_rd_en", 64'(rd_en_o), 64'(0));
        check("rst_valid", 64'(ext_valid_o), 64'(0));
        check("rst_data", 64'(ext_data_o), 64'(0));
        check("rst_tail", 64'(read_tail_snoop), 64'(0));
        @(negedge clk);
        nrst = 1'b1;

        // Single line, then the same pattern under 1-0-0-1 backpressure.
        mem[0] = counting_line();
        write_head_i = ADDR_WIDTH'(1);
        drain(1, 0, -1, 0, 1'b0);
        mem[1] = counting_line();
        write_head_i = ADDR_WIDTH'(2);
        drain(1, 1, -1, 0, 1'b0);

        // Empty stall: nothing buffered for 20 cycles, then two lines arrive.
        do_clear();
        write_head_i = '0;
        drain(2, 0, 20, 2, 1'b0);

        // Wrap: drain 31 lines to park the tail at 31, then read 31 and 0.
        do_clear();
        write_head_i = ADDR_WIDTH'(31);
        drain(31, 0, -1, 0, 1'b0);
        write_head_i = ADDR_WIDTH'(1);
        drain(2, 2, -1, 0, 1'b0);

        // Zero length, then a start pulse landing mid-line.
        drain(0, 0, -1, 0, 1'b0);
        write_head_i = ADDR_WIDTH'((m_tail + 3) % NUM_LINES);
        drain(3, 2, -1, 0, 1'b1);

        for (int r = 0; r < 4; r++) begin
            len = $urandom_range(1, 4);
            for (int l = 0; l < len; l++) mem[(m_tail + l) % NUM_LINES] = random_line();
            write_head_i = ADDR_WIDTH'((m_tail + len) % NUM_LINES);
            drain(len, 2, -1, 0, 1'b0);
        end

        // Clear with beat 3 on the bus.
        run_to_beat3(1);
        clear_i = 1'b1;
        @(negedge clk);
        check("beat3_data", 64'(ext_data_o), 64'(4));
        @(posedge clk); #1;
        clear_i = 1'b0;
        m_tail = 0;
        @(negedge clk);
        check("clear_valid", 64'(ext_valid_o), 64'(0));
        check("clear_tail_mid", 64'(read_tail_snoop), 64'(0));
        check("clear_busy", 64'(busy_o), 64'(0));
        check("clear_no_done", 64'(done_o), 64'(0));
        @(negedge clk);
        check("clear_no_done_late", 64'(done_o), 64'(0));
        check("clear_no_read", 64'(rd_en_o), 64'(0));

        // Async reset with beat 3 on the bus.
        mem[0] = random_line();
        mem[1] = random_line();
        run_to_beat3(2);
        nrst = 1'b0;
        #1;
        check("arst_busy", 64'(busy_o), 64'(0));
        check("arst_done", 64'(done_o), 64'(0));
        check("arst_rd_en", 64'(rd_en_o), 64'(0));
        check("arst_rd_addr", 64'(rd_addr_o), 64'(0));
        check("arst_valid", 64'(ext_valid_o), 64'(0));
        check("arst_data", 64'(ext_data_o), 64'(0));
        check("arst_last", 64'(ext_last_o), 64'(0));
        check("arst_tail", 64'(read_tail_snoop), 64'(0));
        @(negedge clk);
        nrst = 1'b1;
        m_tail = 0;
        mem[0] = random_line();
        write_head_i = ADDR_WIDTH'(1);
        drain(1, 2, -1, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
